// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer-type and transfer-size encodings.
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;
  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;
endpackage

// File: rtl/ahb_subordinate_bridge_if.sv
// ahb_subordinate_bridge_if: AHB subordinate port and generic memory-style bus.
interface ahb_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  modport subordinate (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA, HWSTRB, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
  modport manager (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA, HWSTRB, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;
  logic        error;
  modport cpu (
    output addr, wdata, ren, wen, byte_en,
    input  rdata, busy, error
  );
  modport generic_bus (
    input  addr, wdata, ren, wen, byte_en,
    output rdata, busy, error
  );
endinterface

// File: rtl/ahb_byte_lane_decode.sv
// ahb_byte_lane_decode: byte-lane mask for a read from transfer size and low address bits.
module ahb_byte_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] byte_en
);
  assign byte_en = size == HSIZE_BYTE ? 4'b0001 << addr :
                   size == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: rtl/ahb_subordinate_bridge.sv
// ahb_subordinate_bridge: AHB subordinate translating transfers onto a generic bus,
// with wait-state stretching and a two-cycle ERROR response.
module ahb_subordinate_bridge
  import ahb_pkg::*;
#(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input logic          CLK,
  input logic          nRST,
  ahb_if.subordinate   ahb_s,
  generic_bus_if.cpu   gen_bus_if
);
  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_in;
  logic        write_q;
  logic [2:0]  size_q;
  logic        valid, size_err, align_err, bad, hready_out, take;
  logic [3:0]  rd_be;
  assign valid = ahb_s.HSEL && ahb_s.HREADY &&
                 (ahb_s.HTRANS == HTRANS_NONSEQ || ahb_s.HTRANS == HTRANS_SEQ);
  assign size_err  = ahb_s.HSIZE > HSIZE_WORD;
  assign align_err = (ahb_s.HSIZE == HSIZE_WORD && ahb_s.HADDR[1:0] != 2'b00) ||
                     (ahb_s.HSIZE == HSIZE_HALF && ahb_s.HADDR[0]);
  assign bad = size_err || (ERR_ON_MISALIGN && align_err);
  // Without misalignment errors, drop the address bits below the transfer size.
  assign addr_in = ERR_ON_MISALIGN ? ahb_s.HADDR :
                   {ahb_s.HADDR[31:2],
                    ahb_s.HADDR[1] && ahb_s.HSIZE != HSIZE_WORD,
                    ahb_s.HADDR[0] && ahb_s.HSIZE == HSIZE_BYTE};
  assign hready_out = state_q == IDLE || state_q == ERR2 ||
                      (state_q == ACCESS && !gen_bus_if.busy && !gen_bus_if.error);
  assign take = valid && hready_out;
  always_comb begin
    state_d = IDLE;
    state_d = take ? (bad ? ERR1 : ACCESS) :
              state_q == ERR1 ? ERR2 :
              state_q == ACCESS && gen_bus_if.busy ? ACCESS :
              state_q == ACCESS && gen_bus_if.error ? ERR1 : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q  <= addr_in;
        write_q <= ahb_s.HWRITE;
        size_q  <= ahb_s.HSIZE;
      end
    end
  end
  ahb_byte_lane_decode u_decode (
    .size    (size_q),
    .addr    (addr_q[1:0]),
    .byte_en (rd_be)
  );
  assign ahb_s.HREADYOUT    = hready_out;
  assign ahb_s.HRESP        = state_q == ERR1 || state_q == ERR2;
  assign ahb_s.HRDATA       = gen_bus_if.rdata;
  assign gen_bus_if.addr    = {addr_q[31:2], 2'b00};
  assign gen_bus_if.wdata   = ahb_s.HWDATA;
  assign gen_bus_if.ren     = state_q == ACCESS && !write_q;
  assign gen_bus_if.wen     = state_q == ACCESS && write_q;
  assign gen_bus_if.byte_en = write_q ? ahb_s.HWSTRB : rd_be;
endmodule

// File: tb/tb_ahb_subordinate_bridge.sv
// tb_ahb_subordinate_bridge: directed vectors with a queued per-cycle expectation
// scoreboard, checked by an independent negedge monitor.
module tb_ahb_subordinate_bridge;
  import ahb_pkg::*;
  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [2:0]  m;
  } exp_t;
  logic CLK, nRST;
  int checks, errors, vec;
  exp_t q[$];
  ahb_if ahb ();
  generic_bus_if gbus ();
  assign ahb.HREADY = ahb.HREADYOUT;
  ahb_subordinate_bridge dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ahb_s      (ahb),
    .gen_bus_if (gbus)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", n, vec, act, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hreadyout", {31'b0, ahb.HREADYOUT}, {31'b0, e.f[3]});
      chk("hresp", {31'b0, ahb.HRESP}, {31'b0, e.f[2]});
      chk("ren", {31'b0, gbus.ren}, {31'b0, e.f[1]});
      chk("wen", {31'b0, gbus.wen}, {31'b0, e.f[0]});
      if (e.m[0]) begin
        chk("addr", gbus.addr, e.a);
        chk("byte_en", {28'b0, gbus.byte_en}, {28'b0, e.be});
      end
      if (e.m[1]) chk("wdata", gbus.wdata, e.wd);
      if (e.m[2]) chk("hrdata", ahb.HRDATA, e.rd);
      vec++;
    end
  end
  // f = {HREADYOUT, HRESP, ren, wen}; m = {check hrdata, check wdata, check addr/byte_en}
  task automatic step(input logic [3:0] f, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] rd, input logic [2:0] m);
    exp_t e;
    e.f = f; e.a = a; e.be = be; e.wd = wd; e.rd = rd; e.m = m;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask
  task automatic ok(input logic [3:0] f);
    step(f, 32'h0, 4'h0, 32'h0, 32'h0, 3'b000);
  endtask
  task automatic addr_ph(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic [2:0] sz);
    ahb.HSEL = sel; ahb.HTRANS = tr; ahb.HADDR = a; ahb.HWRITE = wr; ahb.HSIZE = sz;
  endtask
  task automatic idle_ph();
    addr_ph(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_BYTE);
  endtask
  task automatic gen(input logic b, input logic er, input logic [31:0] rd);
    gbus.busy = b; gbus.error = er; gbus.rdata = rd;
  endtask
  initial begin
    checks = 0; errors = 0; vec = 0;
    nRST = 1'b0;
    idle_ph();
    ahb.HBURST = 3'b000; ahb.HMASTLOCK = 1'b0; ahb.HWDATA = '0; ahb.HWSTRB = '0;
    gen(1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    ok(4'b1000);
    nRST = 1'b1;
    ok(4'b1000);
    // single zero-wait word read
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h100, 1'b0, HSIZE_WORD);
    ok(4'b1000);
    idle_ph(); gen(1'b0, 1'b0, 32'hDEADBEEF);
    step(4'b1010, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3'b101);
    ok(4'b1000);
    // halfword write with 3 wait states; next address held while HREADY is low
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h204, 1'b1, HSIZE_HALF);
    ok(4'b1000);
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h300, 1'b0, HSIZE_WORD);
    ahb.HWDATA = 32'hABCD0000; ahb.HWSTRB = 4'b1100; gen(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(4'b0001, 32'h204, 4'b1100, 32'hABCD0000, 32'h0, 3'b011);
    gen(1'b0, 1'b0, 32'h0);
    step(4'b1001, 32'h204, 4'b1100, 32'hABCD0000, 32'h0, 3'b011);
    idle_ph(); gen(1'b0, 1'b0, 32'h0BADF00D);
    step(4'b1010, 32'h300, 4'b1111, 32'h0, 32'h0BADF00D, 3'b101);
    ok(4'b1000);
    // generic bus error
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h40, 1'b0, HSIZE_WORD);
    ok(4'b1000);
    idle_ph(); gen(1'b0, 1'b1, 32'h0);
    step(4'b0010, 32'h40, 4'b1111, 32'h0, 32'h0, 3'b001);
    gen(1'b0, 1'b0, 32'h0);
    ok(4'b0100);
    ok(4'b1100);
    ok(4'b1000);
    // misaligned word read
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h102, 1'b0, HSIZE_WORD);
    ok(4'b1000);
    idle_ph();
    ok(4'b0100);
    ok(4'b1100);
    ok(4'b1000);
    // misaligned half, IDLE during ERR1 ignored, new transfer accepted in ERR2
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h101, 1'b0, HSIZE_HALF);
    ok(4'b1000);
    addr_ph(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
    ok(4'b0100);
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD);
    ok(4'b1100);
    idle_ph(); gen(1'b0, 1'b0, 32'h12345678);
    step(4'b1010, 32'h20, 4'b1111, 32'h0, 32'h12345678, 3'b101);
    ok(4'b1000);
    // oversized transfer is always an error
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h0, 1'b0, 3'b011);
    ok(4'b1000);
    idle_ph();
    ok(4'b0100);
    ok(4'b1100);
    ok(4'b1000);
    // back-to-back read 0x10 then write 0x14
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD);
    ok(4'b1000);
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h14, 1'b1, HSIZE_WORD); gen(1'b0, 1'b0, 32'h11112222);
    step(4'b1010, 32'h10, 4'b1111, 32'h0, 32'h11112222, 3'b101);
    idle_ph(); ahb.HWDATA = 32'h55AA55AA; ahb.HWSTRB = 4'b1111;
    step(4'b1001, 32'h14, 4'b1111, 32'h55AA55AA, 32'h0, 3'b011);
    ok(4'b1000);
    // read byte-lane decode: half 0x102, byte 0x103, byte 0x101
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h102, 1'b0, HSIZE_HALF);
    ok(4'b1000);
    addr_ph(1'b1, HTRANS_SEQ, 32'h103, 1'b0, HSIZE_BYTE);
    step(4'b1010, 32'h100, 4'b1100, 32'h0, 32'h0, 3'b001);
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h101, 1'b0, HSIZE_BYTE);
    step(4'b1010, 32'h100, 4'b1000, 32'h0, 32'h0, 3'b001);
    idle_ph();
    step(4'b1010, 32'h100, 4'b0010, 32'h0, 32'h0, 3'b001);
    ok(4'b1000);
    // reset during a stalled access
    addr_ph(1'b1, HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD);
    ok(4'b1000);
    idle_ph(); gen(1'b1, 1'b0, 32'h0);
    step(4'b0010, 32'h30, 4'b1111, 32'h0, 32'h0, 3'b001);
    nRST = 1'b0;
    ok(4'b0010);
    nRST = 1'b1;
    ok(4'b1000);
    gen(1'b0, 1'b0, 32'h0);
    ok(4'b1000);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_subordinate_bridge.md
AHB_SUBORDINATE_BRIDGE -- requirements
Module: ahb_subordinate_bridge

Interface
REQ-001 SHALL have one parameter: ERR_ON_MISALIGN, default 1, meaning 1 = misaligned transfers get an ERROR response; 0 = the low address bits are masked and the transfer proceeds.
REQ-002 SHALL have port CLK, input, 1 bit: the only clock.
REQ-003 SHALL have port nRST, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port ahb_s, ahb_if.subordinate modport: HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST, HMASTLOCK, HWDATA[31:0], HWSTRB[3:0] and HREADY in; HREADYOUT, HRESP, HRDATA[31:0] out.
REQ-005 SHALL have port gen_bus_if, generic_bus_if.cpu modport: addr[31:0], wdata[31:0], ren, wen and byte_en[3:0] out; rdata[31:0], busy and error in.

Function
REQ-006 SHALL accept an address phase when HSEL=1, HTRANS is NONSEQ or SEQ, and HREADY=1, all in the same cycle.
REQ-007 SHALL register HADDR, HWRITE and HSIZE on acceptance; HBURST and HMASTLOCK are ignored.
REQ-008 SHALL implement states IDLE, ACCESS, ERR1 and ERR2.
REQ-009 SHALL in IDLE, or for HTRANS IDLE/BUSY, or for HSEL=0, drive HREADYOUT=1 and HRESP=0 (zero-wait OKAY).
REQ-010 SHALL transition to ACCESS on an accepted aligned transfer, and to ERR1 on an accepted misaligned transfer when ERR_ON_MISALIGN=1.
REQ-011 SHALL treat a transfer as misaligned when: word with addr[1:0]!=0; halfword with addr[0]=1; or HSIZE>3'b010, which is always an error.
REQ-012 SHALL in ACCESS drive gen addr={addr_q[31:2],2'b00}, and drive ren=~write_q and wen=write_q.
REQ-013 SHALL in ACCESS drive wdata=HWDATA live from the data phase.
REQ-014 SHALL in ACCESS drive byte_en as follows: writes = HWSTRB live; reads = decoded mask (byte: 4'b0001<<addr_q[1:0]; half: addr_q[1]?4'b1100:4'b0011; word: 4'b1111).
REQ-015 SHALL in ACCESS hold HREADYOUT=0 while busy=1.
REQ-016 SHALL complete ACCESS on the first cycle with busy=0 and error=0: HREADYOUT=1, HRESP=0, HRDATA=rdata combinationally in that cycle.
REQ-017 SHALL on busy=0 with error=1 in ACCESS go to ERR1 without asserting HREADYOUT.
REQ-018 SHALL in ERR1 drive HRESP=1 and HREADYOUT=0, and deassert ren/wen; ERR1 goes to ERR2 unconditionally.
REQ-019 SHALL in ERR2 drive HRESP=1 and HREADYOUT=1.
REQ-020 SHALL accept a new address phase in the completing ACCESS cycle or in ERR2 (back-to-back, zero idle cycles); otherwise it goes to IDLE.
REQ-021 SHALL ignore an HTRANS=IDLE issued during ERR1 (manager cancellation), with no generic access started.
REQ-022 SHALL keep ren/wen at 0 outside ACCESS; HRDATA is don't-care except in the completing cycle.
REQ-023 SHALL not update address-phase registers while HREADY=0.

Reset
REQ-024 SHALL with nRST=0 at a CLK edge set: state=IDLE, HREADYOUT=1, HRESP=0, ren=0, wen=0, addr_q=0, write_q=0, size_q=0.
REQ-025 SHALL let reset mid-ACCESS abandon the generic transaction: ren/wen are 0 the cycle after reset, with no completion reported.

Structure
REQ-026 SHALL take HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HSIZE encodings (BYTE, HALF, WORD) from shared package ahb_pkg.
REQ-027 SHALL keep the state typedef local to the module.
REQ-028 SHALL place the read byte-lane decode in sub-module ahb_byte_lane_decode (inputs: size[2:0], addr[1:0]; output: byte_en[3:0]).

Verification
REQ-029 SHALL cover a single read, zero wait: NONSEQ read HADDR=0x100, HSIZE=WORD, busy=0, rdata=0xDEADBEEF -> next cycle ren=1, addr=0x100, byte_en=1111, HREADYOUT=1, HRDATA=0xDEADBEEF.
REQ-030 SHALL cover a write with 3 wait states: NONSEQ write HADDR=0x204, HSIZE=HALF, HWSTRB=1100, HWDATA=0xABCD0000, busy high 3 cycles -> HREADYOUT=0 for 3 cycles, wen=1, byte_en=1100, HREADYOUT=1 on cycle 4.
REQ-031 SHALL cover a generic error: read with busy=0, error=1 -> ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1), then OKAY.
REQ-032 SHALL cover misalignment: word read HADDR=0x102 with ERR_ON_MISALIGN=1 -> ren never asserted, two-cycle ERROR response.
REQ-033 SHALL cover back-to-back: read 0x10 then write 0x14 pipelined -> write address captured in the read completion cycle, wen=1 the following cycle, no idle gap.
REQ-034 SHALL cover reset mid-operation: nRST=0 during an ACCESS with busy=1 -> ren=0, HREADYOUT=1, state=IDLE after the edge.
